// File: rtl/ssit_clear_ctrl.sv
// Store-set clearing sequencer: periodically walks the SSIT clearing every entry
// in idle write-port cycles, then pulses an LFST flush. Option macro: SSIT_CLR_VIOL_TRIG_EN.
module ssit_clear_ctrl #(
  parameter int IDX_W       = 10,
  parameter int CNT_W       = 16,
  parameter int INTERVAL    = 50000,
  parameter int VIOL_THRESH = 200
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable_in,
  input  logic             force_in,
  input  logic             violation_in,
  input  logic             ssit_wr_busy_in,
  output logic             ssit_clr_we_out,
  output logic [IDX_W-1:0] ssit_clr_index_out,
  output logic             lfst_flush_out,
  output logic             sweep_active_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INTERVAL - 1);
  localparam logic [IDX_W-1:0] PTR_MAX  = {IDX_W{1'b1}};

  logic [1:0]       state;
  logic [CNT_W-1:0] int_cnt;
  logic [IDX_W-1:0] ptr;
  logic             interval_hit;
  logic             viol_hit;
  logic             start;

  assign interval_hit = enable_in && (int_cnt == LAST_CNT);
  // Any combination of triggers in one cycle collapses into a single sweep start.
  assign start        = force_in || interval_hit || viol_hit;

`ifdef SSIT_CLR_VIOL_TRIG_EN
  localparam logic [7:0] VIOL_TH = 8'(VIOL_THRESH);

  logic [7:0] viol_cnt;
  logic [7:0] viol_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    viol_inc = viol_cnt;
    if (violation_in && (viol_cnt != 8'hff)) begin
      viol_inc = viol_cnt + 8'd1;
    end
  end

  // Counting in the current pulse lets the threshold-reaching violation start the sweep itself.
  assign viol_hit = (state == ST_IDLE) && (viol_inc >= VIOL_TH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      viol_cnt <= '0;
    end else if (state == ST_IDLE) begin
      viol_cnt <= start ? 8'd0 : viol_inc;
    end
  end
`else
  logic unused_viol;

  assign viol_hit    = 1'b0;
  assign unused_viol = violation_in & (VIOL_THRESH != 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      int_cnt <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SWEEP;
            int_cnt <= '0;
          end else if (enable_in) begin
            int_cnt <= int_cnt + CNT_W'(1);
          end
        end
        ST_SWEEP: begin
          // A busy port stalls the pointer so no entry is skipped.
          if (!ssit_wr_busy_in) begin
            ptr <= ptr + IDX_W'(1);
            if (ptr == PTR_MAX) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          ptr   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          ptr   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ssit_clr_we_out    = (state == ST_SWEEP) && !ssit_wr_busy_in;
  assign ssit_clr_index_out = ptr;
  assign lfst_flush_out     = (state == ST_FLUSH);
  assign sweep_active_out   = (state == ST_SWEEP) || (state == ST_FLUSH);

endmodule
